vga_timing_gen: RTL and testbench

- Parametrised VGA/raster timing generator; successor to the team's fixed 640x480 sync block.
- Sits between the pixel-clock domain and the frame renderer.
- Produces HS/VS with programmable polarity, a display-enable, active-area pixel coordinates and line/frame strobes.
- Output alignment to a downstream pixel pipeline is configurable; start/stop is clean on frame boundaries.

---
 rtl/vga_pkg.sv | 67 ++++++
 rtl/vga_delay_line.sv | 52 +++++
 rtl/vga_timing_gen.sv | 192 +++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing definitions: FSM state encoding, per-mode timing
// tables and a helper that turns a mode into line/frame totals and sync
// window bounds.
package vga_pkg;

  // Generator state; IDLE holds counters at zero with every output inactive.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } vga_state_e;

  // Porch/sync widths of one video mode, in pixels (h) and lines (v).
  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_mode_t;

  // Derived values; sync is asserted for start <= count < end.
  typedef struct packed {
    int h_total;
    int hs_start;
    int hs_end;
    int v_total;
    int vs_start;
    int vs_end;
  } vga_bounds_t;

  // 640x480@60, 25.175 MHz pixel clock, both syncs active-low.
  localparam vga_mode_t MODE_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
  };
  localparam bit MODE_640X480_60_HS_POL = 1'b0;
  localparam bit MODE_640X480_60_VS_POL = 1'b0;

  // 800x600@60, 40 MHz pixel clock, both syncs active-high.
  localparam vga_mode_t MODE_800X600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
  };
  localparam bit MODE_800X600_60_HS_POL = 1'b1;
  localparam bit MODE_800X600_60_VS_POL = 1'b1;

  // Deepest output alignment pipeline the generator is meant to be built with.
  localparam int PIPE_MAX = 4;

  // Line order is active, front porch, sync, back porch, so the sync window
  // starts right after the front porch.
  function automatic vga_bounds_t vga_calc_bounds(input vga_mode_t m);
    vga_bounds_t b;
    b.h_total  = m.h_active + m.h_fp + m.h_sync + m.h_bp;
    b.hs_start = m.h_active + m.h_fp;
    b.hs_end   = m.h_active + m.h_fp + m.h_sync;
    b.v_total  = m.v_active + m.v_fp + m.v_sync + m.v_bp;
    b.vs_start = m.v_active + m.v_fp;
    b.vs_end   = m.v_active + m.v_fp + m.v_sync;
    return b;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Pixel-tick gated shift register used to align every timing output to a
// downstream pixel pipeline. DEPTH=0 is a straight wire.
module vga_delay_line #(
  parameter int         W       = 8,
  parameter int         DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, resetn, en};
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    // Shift one place per pixel tick; hold every stage otherwise.
    always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i];
      end
      if (en) begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    // Stage registers; reset loads the per-bit idle pattern into every stage.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator. A pixel-tick qualified h/v counter
// pair, a start/stop FSM that only starts and stops on frame boundaries,
// one register stage of decoded timing, then PIPE alignment stages.
//
// There is no valid/ready handshake here: pix_en is a pure qualifier. Every
// flop in the block (FSM, counters, output stages) changes only on a clk
// edge where pix_en=1, so with pix_en low all outputs hold.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int PIPE     = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          pix_en,
  input  logic          run,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          display,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy,
  output vga_state_e    dbg_state
);

  localparam vga_mode_t MODE = '{
    h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
  };
  localparam vga_bounds_t BND = vga_calc_bounds(MODE);

  // Counter compare points. Sync bounds are one bit wider because a window
  // that ends exactly at the total may equal 2^CW.
  localparam logic [CW-1:0] H_LAST   = CW'(BND.h_total - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(BND.v_total - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW:0]   HS_START = (CW+1)'(BND.hs_start);
  localparam logic [CW:0]   HS_END   = (CW+1)'(BND.hs_end);
  localparam logic [CW:0]   VS_START = (CW+1)'(BND.vs_start);
  localparam logic [CW:0]   VS_END   = (CW+1)'(BND.vs_end);

  // Output bus layout through the alignment pipeline.
  localparam int BW = 6 + 2 * CW;
  localparam logic [BW-1:0] BUS_RST = {~HS_POL, ~VS_POL, {(4 + 2 * CW){1'b0}}};

  vga_state_e    state_q, state_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;

  // Stage-0 outputs, decoded from the counter values before they advance.
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          display_q, display_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          busy_q, busy_d;

  logic          h_last;
  logic          v_last;
  logic          frame_end;
  logic          counting;
  logic          in_hs;
  logic          in_vs;
  logic          in_active;

  // Position decode shared by the FSM, counters and stage-0 outputs.
  always_comb begin
    h_last    = (h_q == H_LAST);
    v_last    = (v_q == V_LAST);
    frame_end = h_last && v_last;
    // An IDLE tick with run high already produces pixel (0,0), so the first
    // frame_start appears one clk after that tick.
    counting  = (state_q != ST_IDLE) || run;
    in_hs     = ({1'b0, h_q} >= HS_START) && ({1'b0, h_q} < HS_END);
    in_vs     = ({1'b0, v_q} >= VS_START) && ({1'b0, v_q} < VS_END);
    in_active = (h_q < H_ACT) && (v_q < V_ACT);
  end

  // Next-state, counter and stage-0 decode; everything holds unless pix_en.
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    v_d           = v_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    display_d     = display_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    busy_d        = busy_q;

    if (pix_en) begin
      case (state_q)
        ST_IDLE: begin
          if (run) state_d = ST_RUN;
        end
        ST_RUN: begin
          // Dropping run on the very last tick needs no extra frame.
          if (!run) state_d = frame_end ? ST_IDLE : ST_STOP;
        end
        ST_STOP: begin
          // Returning run just keeps counting, so there is no discontinuity.
          if (run) state_d = ST_RUN;
          else if (frame_end) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (counting) begin
        h_d = h_last ? '0 : h_q + 1'b1;
        if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
      end

      hs_d          = (counting && in_hs) ? HS_POL : ~HS_POL;
      vs_d          = (counting && in_vs) ? VS_POL : ~VS_POL;
      display_d     = counting && in_active;
      x_d           = (counting && in_active) ? h_q : '0;
      y_d           = (counting && in_active) ? v_q : '0;
      line_start_d  = counting && (h_q == '0);
      frame_start_d = counting && (h_q == '0) && (v_q == '0);
      busy_d        = counting;
    end
  end

  // FSM, counters and stage-0 registers; reset aborts any frame at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      display_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      display_q     <= display_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  logic [BW-1:0] bus_s0;
  logic [BW-1:0] bus_out;

  assign bus_s0 = {hs_q, vs_q, display_q, line_start_q, frame_start_q, busy_q, x_q, y_q};

  // Every output goes through the same delay so relative alignment is kept.
  vga_delay_line #(
    .W       (BW),
    .DEPTH   (PIPE),
    .RST_VAL (BUS_RST)
  ) u_align (
    .clk    (clk),
    .resetn (resetn),
    .en     (pix_en),
    .d      (bus_s0),
    .q      (bus_out)
  );

  assign {vga_hs, vga_vs, display, line_start, frame_start, busy, x, y} = bus_out;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Three instances share the inputs:
// the default 640x480 mode (line-level timing), a 16x11 miniature mode for
// frame-level behaviour, and the same miniature mode with PIPE=3 and
// active-high syncs.
module tb_vga_timing_gen;
  import vga_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic pix_en = 1'b0;
  logic run = 1'b0;

  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  logic a_hs, a_vs, a_disp, a_ls, a_fs, a_busy;
  logic [9:0] a_x, a_y;
  vga_state_e a_state;

  logic s_hs, s_vs, s_disp, s_ls, s_fs, s_busy;
  logic [4:0] s_x, s_y;
  vga_state_e s_state;

  logic p_hs, p_vs, p_disp, p_ls, p_fs, p_busy;
  logic [4:0] p_x, p_y;
  vga_state_e p_state;

  vga_timing_gen #(.PIPE(0)) dut_a (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .run(run),
    .vga_hs(a_hs), .vga_vs(a_vs), .display(a_disp), .x(a_x), .y(a_y),
    .line_start(a_ls), .frame_start(a_fs), .busy(a_busy), .dbg_state(a_state)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(5), .PIPE(0)
  ) dut_s (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .run(run),
    .vga_hs(s_hs), .vga_vs(s_vs), .display(s_disp), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .busy(s_busy), .dbg_state(s_state)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(5), .PIPE(3)
  ) dut_p (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .run(run),
    .vga_hs(p_hs), .vga_vs(p_vs), .display(p_disp), .x(p_x), .y(p_y),
    .line_start(p_ls), .frame_start(p_fs), .busy(p_busy), .dbg_state(p_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- event monitor ----------------
  // Records edge times (in clk cycles) of the interesting outputs so the
  // directed steps can compare periods and widths against fixed numbers.
  logic mon_clr = 1'b1;
  int cyc = 0;
  int s_fs_r[$], s_fs_f[$], s_ls_r[$], s_ls_f[$];
  int s_hs_f[$], s_hs_r[$], s_vs_f[$], s_vs_r[$], s_busy_f[$];
  int p_fs_r[$], p_hs_r[$], p_busy_f[$];
  int a_ls_r[$], a_hs_f[$], a_hs_r[$];
  int s_disp_at_fs[$], s_ls_at_fs[$];
  int s_disp_cnt = 0, s_ls_cnt = 0;
  int coord_bad = 0, hold_bad = 0, x_max = 0, y_max = 0;

  logic s_fs_q = 1'b0, s_ls_q = 1'b0, s_hs_q = 1'b1, s_vs_q = 1'b1;
  logic s_busy_q = 1'b0, s_disp_q = 1'b0, rstn_q = 1'b0;
  logic p_fs_q = 1'b0, p_hs_q = 1'b0, p_busy_q = 1'b0;
  logic a_ls_q = 1'b0, a_hs_q = 1'b1;
  logic [4:0] s_x_q = '0;
  logic [15:0] s_bus, s_bus_q = '0;

  assign s_bus = {s_hs, s_vs, s_disp, s_ls, s_fs, s_busy, s_x, s_y};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      s_fs_r.delete(); s_fs_f.delete(); s_ls_r.delete(); s_ls_f.delete();
      s_hs_f.delete(); s_hs_r.delete(); s_vs_f.delete(); s_vs_r.delete();
      s_busy_f.delete(); p_fs_r.delete(); p_hs_r.delete(); p_busy_f.delete();
      a_ls_r.delete(); a_hs_f.delete(); a_hs_r.delete();
      s_disp_at_fs.delete(); s_ls_at_fs.delete();
      s_disp_cnt <= 0; s_ls_cnt <= 0;
      coord_bad <= 0; hold_bad <= 0; x_max <= 0; y_max <= 0;
    end else begin
      if (s_fs && !s_fs_q) begin
        s_fs_r.push_back(cyc);
        s_disp_at_fs.push_back(s_disp_cnt);
        s_ls_at_fs.push_back(s_ls_cnt);
      end
      if (!s_fs && s_fs_q) s_fs_f.push_back(cyc);
      if (s_ls && !s_ls_q) begin
        s_ls_r.push_back(cyc);
        s_ls_cnt <= s_ls_cnt + 1;
      end
      if (!s_ls && s_ls_q) s_ls_f.push_back(cyc);
      if (!s_hs && s_hs_q) s_hs_f.push_back(cyc);
      if (s_hs && !s_hs_q) s_hs_r.push_back(cyc);
      if (!s_vs && s_vs_q) s_vs_f.push_back(cyc);
      if (s_vs && !s_vs_q) s_vs_r.push_back(cyc);
      if (!s_busy && s_busy_q) s_busy_f.push_back(cyc);
      if (p_fs && !p_fs_q) p_fs_r.push_back(cyc);
      if (p_hs && !p_hs_q) p_hs_r.push_back(cyc);
      if (!p_busy && p_busy_q) p_busy_f.push_back(cyc);
      if (a_ls && !a_ls_q) a_ls_r.push_back(cyc);
      if (!a_hs && a_hs_q) a_hs_f.push_back(cyc);
      if (a_hs && !a_hs_q) a_hs_r.push_back(cyc);
      if (s_disp) begin
        s_disp_cnt <= s_disp_cnt + 1;
        if (int'(s_x) > x_max) x_max <= int'(s_x);
        if (int'(s_y) > y_max) y_max <= int'(s_y);
        if (s_x >= 5'd8 || s_y >= 5'd6) coord_bad <= coord_bad + 1;
        if (s_disp_q && pix_en && resetn && rstn_q && s_x != 5'(s_x_q + 5'd1))
          coord_bad <= coord_bad + 1;
      end else if (s_x != 5'd0 || s_y != 5'd0) begin
        coord_bad <= coord_bad + 1;
      end
      if (!pix_en && resetn && rstn_q && s_bus != s_bus_q) hold_bad <= hold_bad + 1;
    end
    s_fs_q <= s_fs; s_ls_q <= s_ls; s_hs_q <= s_hs; s_vs_q <= s_vs;
    s_busy_q <= s_busy; s_disp_q <= s_disp; s_x_q <= s_x; s_bus_q <= s_bus;
    p_fs_q <= p_fs; p_hs_q <= p_hs; p_busy_q <= p_busy;
    a_ls_q <= a_ls; a_hs_q <= a_hs; rstn_q <= resetn;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic restart(input logic en);
    resetn = 1'b0; run = 1'b0; pix_en = 1'b0; mon_clr = 1'b1;
    step(2);
    resetn = 1'b1; run = 1'b1; pix_en = en; mon_clr = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values on all three instances.
    step(3);
    chk("rst_s_hs", 32'(s_hs), 32'd1);
    chk("rst_s_vs", 32'(s_vs), 32'd1);
    chk("rst_s_disp", 32'(s_disp), 32'd0);
    chk("rst_s_x", 32'(s_x), 32'd0);
    chk("rst_s_y", 32'(s_y), 32'd0);
    chk("rst_s_ls", 32'(s_ls), 32'd0);
    chk("rst_s_fs", 32'(s_fs), 32'd0);
    chk("rst_s_busy", 32'(s_busy), 32'd0);
    chk("rst_s_state", 32'(s_state), 32'(ST_IDLE));
    chk("rst_p_hs", 32'(p_hs), 32'd0);
    chk("rst_p_vs", 32'(p_vs), 32'd0);
    chk("rst_p_ls", 32'(p_ls), 32'd0);
    chk("rst_p_y", 32'(p_y), 32'd0);
    chk("rst_p_state", 32'(p_state), 32'(ST_IDLE));
    chk("rst_a_hs", 32'(a_hs), 32'd1);
    chk("rst_a_vs", 32'(a_vs), 32'd1);
    chk("rst_a_disp", 32'(a_disp), 32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_x", 32'(a_x), 32'd0);
    chk("rst_a_y", 32'(a_y), 32'd0);
    chk("rst_a_state", 32'(a_state), 32'(ST_IDLE));

    // Start with pix_en=1: pixel (0,0) appears one clk after the first tick.
    resetn = 1'b1; run = 1'b1; pix_en = 1'b1; mon_clr = 1'b0;
    step(1);
    chk("first_s_fs", 32'(s_fs), 32'd1);
    chk("first_s_ls", 32'(s_ls), 32'd1);
    chk("first_s_disp", 32'(s_disp), 32'd1);
    chk("first_s_busy", 32'(s_busy), 32'd1);
    chk("first_s_hs", 32'(s_hs), 32'd1);
    chk("first_a_fs", 32'(a_fs), 32'd1);
    chk("first_s_state", 32'(s_state), 32'(ST_RUN));
    chk("first_p_fs", 32'(p_fs), 32'd0);
    step(2);
    chk("pipe3_before", 32'(p_fs), 32'd0);
    step(1);
    chk("pipe3_fs", 32'(p_fs), 32'd1);
    chk("pipe3_busy", 32'(p_busy), 32'd1);
    chk("pipe3_disp", 32'(p_disp), 32'd1);
    chk("pipe3_x", 32'(p_x), 32'd0);
    chk("s_x_at_3", 32'(s_x), 32'd3);

    step(1700);
    chk("a_line_period", 32'(a_ls_r[1] - a_ls_r[0]), 32'd800);
    chk("a_hs_offset", 32'(a_hs_f[0] - a_ls_r[0]), 32'd656);
    chk("a_hs_width", 32'(a_hs_r[0] - a_hs_f[0]), 32'd96);
    chk("s_frame_period", 32'(s_fs_r[1] - s_fs_r[0]), 32'd176);
    chk("s_frame_period2", 32'(s_fs_r[2] - s_fs_r[1]), 32'd176);
    chk("s_fs_width", 32'(s_fs_f[0] - s_fs_r[0]), 32'd1);
    chk("s_ls_width", 32'(s_ls_f[0] - s_ls_r[0]), 32'd1);
    chk("s_line_period", 32'(s_ls_r[1] - s_ls_r[0]), 32'd16);
    chk("s_hs_offset", 32'(s_hs_f[0] - s_fs_r[0]), 32'd10);
    chk("s_hs_width", 32'(s_hs_r[0] - s_hs_f[0]), 32'd3);
    chk("s_vs_offset", 32'(s_vs_f[0] - s_fs_r[0]), 32'd112);
    chk("s_vs_width", 32'(s_vs_r[0] - s_vs_f[0]), 32'd32);
    chk("s_disp_per_frame", 32'(s_disp_at_fs[1] - s_disp_at_fs[0]), 32'd48);
    chk("s_lines_per_frame", 32'(s_ls_at_fs[1] - s_ls_at_fs[0]), 32'd11);
    chk("s_x_max", 32'(x_max), 32'd7);
    chk("s_y_max", 32'(y_max), 32'd5);
    chk("s_coord_bad", 32'(coord_bad), 32'd0);
    chk("p_fs_shift", 32'(p_fs_r[0] - s_fs_r[0]), 32'd3);
    chk("p_hs_shift", 32'(p_hs_r[0] - s_hs_f[0]), 32'd3);

    // pix_en on every 4th clk: timings scale by 4, outputs hold in between.
    restart(1'b1);
    repeat (200) begin
      pix_en = 1'b1;
      step(1);
      pix_en = 1'b0;
      step(3);
    end
    chk("d4_frame_period", 32'(s_fs_r[1] - s_fs_r[0]), 32'd704);
    chk("d4_fs_width", 32'(s_fs_f[0] - s_fs_r[0]), 32'd4);
    chk("d4_ls_width", 32'(s_ls_f[0] - s_ls_r[0]), 32'd4);
    chk("d4_line_period", 32'(s_ls_r[1] - s_ls_r[0]), 32'd64);
    chk("d4_hs_width", 32'(s_hs_r[0] - s_hs_f[0]), 32'd12);
    chk("d4_vs_width", 32'(s_vs_r[0] - s_vs_f[0]), 32'd128);
    chk("d4_p_fs_shift", 32'(p_fs_r[0] - s_fs_r[0]), 32'd12);
    chk("d4_hold_bad", 32'(hold_bad), 32'd0);
    chk("d4_coord_bad", 32'(coord_bad), 32'd0);

    // run dropped at v=3 and raised again at v=7: next frame is on time.
    restart(1'b1);
    step(53);
    run = 1'b0;
    step(2);
    chk("stop_state", 32'(s_state), 32'(ST_STOP));
    chk("stop_busy", 32'(s_busy), 32'd1);
    step(58);
    run = 1'b1;
    step(250);
    chk("resume_period", 32'(s_fs_r[1] - s_fs_r[0]), 32'd176);
    chk("resume_no_idle", 32'(s_busy_f.size()), 32'd0);
    chk("resume_p_no_idle", 32'(p_busy_f.size()), 32'd0);

    // run dropped at v=3 for good: frame finishes, then idle.
    restart(1'b1);
    step(53);
    run = 1'b0;
    step(200);
    chk("stop_busy_fall", 32'(s_busy_f[0] - s_fs_r[0]), 32'd176);
    chk("stop_one_frame", 32'(s_fs_r.size()), 32'd1);
    chk("stop_vs_seen", 32'(s_vs_f.size()), 32'd1);
    chk("stop_p_busy_fall", 32'(p_busy_f[0] - s_busy_f[0]), 32'd3);
    chk("idle_state", 32'(s_state), 32'(ST_IDLE));
    chk("idle_busy", 32'(s_busy), 32'd0);
    chk("idle_disp", 32'(s_disp), 32'd0);
    chk("idle_hs", 32'(s_hs), 32'd1);
    chk("idle_vs", 32'(s_vs), 32'd1);
    chk("idle_p_hs", 32'(p_hs), 32'd0);

    // Asynchronous reset mid-frame at h=5, v=4, then a clean restart.
    restart(1'b1);
    step(69);
    chk("mid_x", 32'(s_x), 32'd4);
    chk("mid_y", 32'(s_y), 32'd4);
    chk("mid_disp", 32'(s_disp), 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_disp", 32'(s_disp), 32'd0);
    chk("async_x", 32'(s_x), 32'd0);
    chk("async_y", 32'(s_y), 32'd0);
    chk("async_busy", 32'(s_busy), 32'd0);
    chk("async_p_disp", 32'(p_disp), 32'd0);
    chk("async_p_busy", 32'(p_busy), 32'd0);
    step(1);
    resetn = 1'b1;
    step(1);
    chk("rerun_fs", 32'(s_fs), 32'd1);
    chk("rerun_ls", 32'(s_ls), 32'd1);
    chk("rerun_x", 32'(s_x), 32'd0);
    chk("rerun_y", 32'(s_y), 32'd0);
    step(1);
    chk("rerun_fs_drop", 32'(s_fs), 32'd0);
    chk("rerun_x1", 32'(s_x), 32'd1);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
